// File: rtl/axi4_lite_read_master_arbiter_if.sv
// Request/response and AXI4-Lite read-channel bundle for axi4_lite_read_master_arbiter.
// The master modport is the arbiter side; the slave modport is the requester/AXI environment.
interface axi4_lite_read_master_arbiter_if #(
  parameter int NO_OF_REQUESTERS = 4,
  parameter int ADDRESS_WIDTH    = 32,
  parameter int DATA_WIDTH       = 32
);
  logic [NO_OF_REQUESTERS-1:0]                    req_valid;
  logic [NO_OF_REQUESTERS-1:0][ADDRESS_WIDTH-1:0] req_addr;
  logic [NO_OF_REQUESTERS-1:0][2:0]               req_prot;
  logic [NO_OF_REQUESTERS-1:0]                    req_ready;
  logic [NO_OF_REQUESTERS-1:0]                    rsp_valid;
  logic [DATA_WIDTH-1:0]                          rsp_data;
  logic [1:0]                                     rsp_resp;
  logic [ADDRESS_WIDTH-1:0]                       araddr;
  logic [2:0]                                     arprot;
  logic                                           arvalid;
  logic                                           arready;
  logic [DATA_WIDTH-1:0]                          rdata;
  logic [1:0]                                     rresp;
  logic                                           rvalid;
  logic                                           rready;

  modport master (
    input  req_valid, req_addr, req_prot, arready, rdata, rresp, rvalid,
    output req_ready, rsp_valid, rsp_data, rsp_resp, araddr, arprot, arvalid, rready
  );

  modport slave (
    output req_valid, req_addr, req_prot, arready, rdata, rresp, rvalid,
    input  req_ready, rsp_valid, rsp_data, rsp_resp, araddr, arprot, arvalid, rready
  );
endinterface

// File: rtl/axi4_lite_read_master_arbiter.sv
// Round-robin sharing of one AXI4-Lite read channel, one outstanding read at a time.
// Optional AXI4LITE_RD_ADDR_CHECK_EN: out-of-range addresses get a local DECERR, no AR issued.

// Per-requester one-hot decode of the grant pulse and the response pulse.
module axi4_lite_rd_arb_lane #(
  parameter int LANE  = 0,
  parameter int PTR_W = 1
) (
  input  logic [PTR_W-1:0] grant_idx,
  input  logic             grant_en,
  input  logic [PTR_W-1:0] owner_idx,
  input  logic             rsp_en,
  output logic             ready,
  output logic             rsp_vld
);
  localparam logic [PTR_W-1:0] IDX = PTR_W'(LANE);

  assign ready   = grant_en && (grant_idx == IDX);
  assign rsp_vld = rsp_en   && (owner_idx == IDX);
endmodule

module axi4_lite_read_master_arbiter #(
  parameter int                       NO_OF_REQUESTERS = 4,
  parameter int                       ADDRESS_WIDTH    = 32,
  parameter int                       DATA_WIDTH       = 32,
  parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS      = '0,
  parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS      = '1
) (
  input logic aclk,
  input logic areset,
  axi4_lite_read_master_arbiter_if.master bus
);
  localparam int PTR_W = (NO_OF_REQUESTERS > 1) ? $clog2(NO_OF_REQUESTERS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

`ifdef AXI4LITE_RD_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  logic [1:0]               state;
  logic [PTR_W-1:0]         rr_ptr, grant_idx, owner;
  logic                     grant_en, rsp_en, bad_addr;
  logic [ADDRESS_WIDTH-1:0] sel_addr, araddr_q;
  logic [2:0]               sel_prot, arprot_q;
  logic [ADDRESS_WIDTH:0]   lo_diff, hi_diff;
  logic [DATA_WIDTH-1:0]    rsp_data_q;
  logic [1:0]               rsp_resp_q;
  logic [NO_OF_REQUESTERS-1:0] ready_w, rsp_vld_w;
  int                       idx;

  // Walk the search order backwards so the nearest requester after rr_ptr is written last.
  always_comb begin
    grant_idx = rr_ptr;
    idx       = 0;
    for (int k = NO_OF_REQUESTERS; k >= 1; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NO_OF_REQUESTERS) idx = idx - NO_OF_REQUESTERS;
      if (bus.req_valid[idx]) grant_idx = PTR_W'(idx);
    end
  end

  assign grant_en = (state == S_IDLE) && (|bus.req_valid) && !areset;
  assign rsp_en   = (state == S_RESP);
  assign sel_addr = bus.req_addr[grant_idx];
  assign sel_prot = bus.req_prot[grant_idx];

  // Borrow-out of the subtractions flags below-MIN / above-MAX without constant compares.
  assign lo_diff  = {1'b0, sel_addr} - {1'b0, MIN_ADDRESS};
  assign hi_diff  = {1'b0, MAX_ADDRESS} - {1'b0, sel_addr};
  assign bad_addr = ADDR_CHECK && (lo_diff[ADDRESS_WIDTH] || hi_diff[ADDRESS_WIDTH]);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= S_IDLE;
      rr_ptr     <= PTR_W'(NO_OF_REQUESTERS - 1);
      owner      <= '0;
      araddr_q   <= '0;
      arprot_q   <= '0;
      rsp_data_q <= '0;
      rsp_resp_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (grant_en) begin
          owner    <= grant_idx;
          rr_ptr   <= grant_idx;
          araddr_q <= sel_addr;
          arprot_q <= sel_prot;
          if (bad_addr) begin
            rsp_data_q <= '0;
            rsp_resp_q <= 2'b11;
            state      <= S_RESP;
          end else begin
            state <= S_ADDR;
          end
        end
        S_ADDR: if (bus.arready) state <= S_DATA;
        S_DATA: if (bus.rvalid) begin
          rsp_data_q <= bus.rdata;
          rsp_resp_q <= bus.rresp;
          state      <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NO_OF_REQUESTERS; i++) begin : g_lane
    axi4_lite_rd_arb_lane #(.LANE(i), .PTR_W(PTR_W)) u_lane (
      .grant_idx (grant_idx),
      .grant_en  (grant_en),
      .owner_idx (owner),
      .rsp_en    (rsp_en),
      .ready     (ready_w[i]),
      .rsp_vld   (rsp_vld_w[i])
    );
  end

  assign bus.req_ready = ready_w;
  assign bus.rsp_valid = rsp_vld_w;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.araddr    = araddr_q;
  assign bus.arprot    = arprot_q;
  assign bus.arvalid   = (state == S_ADDR);
  assign bus.rready    = (state == S_DATA);
endmodule

// File: tb/tb_axi4_lite_read_master_arbiter.sv
// Bench for axi4_lite_read_master_arbiter: vector table, hand sequences, random vs round-robin model.
module tb_axi4_lite_read_master_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef AXI4LITE_RD_ADDR_CHECK_EN
  localparam logic [31:0] MAX_A = 32'h0000_0FFF;
`else
  localparam logic [31:0] MAX_A = 32'hFFFF_FFFF;
`endif

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi4_lite_read_master_arbiter_if #(.NO_OF_REQUESTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_read_master_arbiter #(
    .NO_OF_REQUESTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
    .MIN_ADDRESS(32'h0), .MAX_ADDRESS(MAX_A)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [2:0]  prot;
    int          ar_wait;
    int          r_wait;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          g;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   model_last = N - 1;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbiter: first requesting index after the last grant, modulo N.
  function automatic int model_grant(input logic [3:0] m);
    for (int k = 1; k <= N; k++)
      if (m[(model_last + k) % N]) return (model_last + k) % N;
    return 0;
  endfunction

  task automatic drive_addrs(input logic [31:0] base, input logic [2:0] prot);
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i] = base + 32'(i * 4);
      bus.req_prot[i] = prot ^ 3'(i);
    end
  endtask

  // One complete read; entered and left at posedge+1 with the DUT idle.
  task automatic run_txn(input vec_t v);
    logic [3:0]  oh;
    logic [31:0] exp_addr;
    logic [2:0]  exp_prot;
    oh       = 4'b0001 << v.g;
    exp_addr = v.addr + 32'(v.g * 4);
    exp_prot = v.prot ^ 3'(v.g);
    drive_addrs(v.addr, v.prot);
    bus.req_valid = v.mask;
    #1;
    chk("req_ready", 64'(bus.req_ready), 64'(oh));
    chk("arvalid_idle", 64'(bus.arvalid), 64'd0);
    @(posedge aclk); #1;
    bus.req_valid = v.mask & ~oh;
    bus.rvalid = 1'b1; bus.rdata = 32'hBAD0_0BAD; bus.rresp = 2'b01;
    for (int k = 0; k <= v.ar_wait; k++) begin
      bus.arready = (k == v.ar_wait);
      #1;
      chk("arvalid", 64'(bus.arvalid), 64'd1);
      chk("araddr", 64'(bus.araddr), 64'(exp_addr));
      chk("arprot", 64'(bus.arprot), 64'(exp_prot));
      chk("rready_in_addr", 64'(bus.rready), 64'd0);
      chk("req_ready_busy", 64'(bus.req_ready), 64'd0);
      @(posedge aclk); #1;
    end
    bus.arready = 1'b0;
    for (int k = 0; k <= v.r_wait; k++) begin
      bus.rvalid = (k == v.r_wait);
      bus.rdata  = (k == v.r_wait) ? v.rdata : 32'h5A5A_A5A5;
      bus.rresp  = (k == v.r_wait) ? v.rresp : 2'b01;
      #1;
      chk("arvalid_in_data", 64'(bus.arvalid), 64'd0);
      chk("rready", 64'(bus.rready), 64'd1);
      chk("rsp_valid_early", 64'(bus.rsp_valid), 64'd0);
      @(posedge aclk); #1;
    end
    bus.rvalid = 1'b0;
    #1;
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
    chk("rsp_data", 64'(bus.rsp_data), 64'(v.rdata));
    chk("rsp_resp", 64'(bus.rsp_resp), 64'(v.rresp));
    chk("rready_in_resp", 64'(bus.rready), 64'd0);
    @(posedge aclk); #1;
    chk("rsp_valid_pulse", 64'(bus.rsp_valid), 64'd0);
    model_last = v.g;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   g;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_prot = '0;
    bus.arready = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rvalid = 1'b0;

    //               mask     addr        prot aw rw rdata          rresp  g
    tbl[0]  = '{4'b1111, 32'h0000_0200, 3'd0, 0, 0, 32'h1111_0000, 2'b00, 0};
    tbl[1]  = '{4'b0100, 32'h0000_00F8, 3'd2, 0, 0, 32'hDEAD_BEEF, 2'b00, 2};
    tbl[2]  = '{4'b1111, 32'h0000_0300, 3'd1, 0, 0, 32'h2222_0003, 2'b01, 3};
    tbl[3]  = '{4'b1111, 32'h0000_0310, 3'd3, 1, 0, 32'h2222_0000, 2'b00, 0};
    tbl[4]  = '{4'b1111, 32'h0000_0320, 3'd4, 0, 1, 32'h2222_0001, 2'b00, 1};
    tbl[5]  = '{4'b1111, 32'h0000_0330, 3'd5, 0, 0, 32'h2222_0002, 2'b00, 2};
    tbl[6]  = '{4'b1111, 32'h0000_0340, 3'd6, 2, 2, 32'h2222_0003, 2'b00, 3};
    tbl[7]  = '{4'b1111, 32'h0000_0350, 3'd7, 0, 0, 32'h2222_0004, 2'b00, 0};
    tbl[8]  = '{4'b0001, 32'h0000_0400, 3'd0, 0, 0, 32'h3333_0000, 2'b00, 0};
    tbl[9]  = '{4'b0001, 32'h0000_0404, 3'd1, 0, 0, 32'h3333_0001, 2'b11, 0};
    tbl[10] = '{4'b1010, 32'h0000_0500, 3'd2, 0, 0, 32'h4444_0001, 2'b00, 1};
    tbl[11] = '{4'b1010, 32'h0000_0510, 3'd3, 0, 0, 32'h4444_0003, 2'b00, 3};
    tbl[12] = '{4'b1010, 32'h0000_0520, 3'd4, 0, 0, 32'h4444_0005, 2'b00, 1};
    tbl[13] = '{4'b0100, 32'h0000_0600, 3'd5, 5, 3, 32'hCAFE_F00D, 2'b10, 2};
    tbl[14] = '{4'b1001, 32'h0000_0700, 3'd6, 0, 0, 32'h5555_0003, 2'b00, 3};
    tbl[15] = '{4'b1001, 32'h0000_0710, 3'd7, 0, 0, 32'h5555_0000, 2'b00, 0};

    // Reset holds every output low even with all requesters asking.
    bus.req_valid = 4'b1111;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_arvalid", 64'(bus.arvalid), 64'd0);
    chk("rst_rready", 64'(bus.rready), 64'd0);
    chk("rst_araddr", 64'(bus.araddr), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rst_rsp_resp", 64'(bus.rsp_resp), 64'd0);
    areset = 1'b0;
    model_last = N - 1;

    for (int i = 0; i < 16; i++) run_txn(tbl[i]);

    // Reset while the read is in its data phase: nothing comes back, arbitration restarts.
    drive_addrs(32'h0000_0800, 3'd5);
    bus.req_valid = 4'b0010;
    #1;
    chk("r5_req_ready", 64'(bus.req_ready), 64'b0010);
    @(posedge aclk); #1;
    bus.req_valid = '0;
    bus.arready = 1'b1;
    #1;
    chk("r5_arvalid", 64'(bus.arvalid), 64'd1);
    @(posedge aclk); #1;
    bus.arready = 1'b0;
    #1;
    chk("r5_rready", 64'(bus.rready), 64'd1);
    areset = 1'b1;
    #1;
    chk("r5_arvalid_rst", 64'(bus.arvalid), 64'd0);
    chk("r5_rready_rst", 64'(bus.rready), 64'd0);
    chk("r5_rsp_valid_rst", 64'(bus.rsp_valid), 64'd0);
    bus.rvalid = 1'b1; bus.rdata = 32'h7777_7777; bus.rresp = 2'b00;
    @(posedge aclk); #1;
    chk("r5_rsp_valid_hold", 64'(bus.rsp_valid), 64'd0);
    areset = 1'b0;
    model_last = N - 1;
    @(posedge aclk); #1;
    chk("r5_rsp_valid_after", 64'(bus.rsp_valid), 64'd0);
    chk("r5_rready_after", 64'(bus.rready), 64'd0);
    bus.rvalid = 1'b0;
    v = '{4'b1111, 32'h0000_0900, 3'd0, 0, 0, 32'h0BAD_F00D, 2'b00, 0};
    run_txn(v);

`ifdef AXI4LITE_RD_ADDR_CHECK_EN
    // Out-of-range request is answered locally with DECERR and no AR.
    drive_addrs(32'h0000_1000, 3'd1);
    bus.req_valid = 4'b0001;
    #1;
    chk("dec_req_ready", 64'(bus.req_ready), 64'b0001);
    @(posedge aclk); #1;
    bus.req_valid = '0;
    #1;
    chk("dec_arvalid", 64'(bus.arvalid), 64'd0);
    chk("dec_rsp_valid", 64'(bus.rsp_valid), 64'b0001);
    chk("dec_rsp_resp", 64'(bus.rsp_resp), 64'd3);
    chk("dec_rsp_data", 64'(bus.rsp_data), 64'd0);
    @(posedge aclk); #1;
    chk("dec_rsp_pulse", 64'(bus.rsp_valid), 64'd0);
    chk("dec_arvalid_after", 64'(bus.arvalid), 64'd0);
    model_last = 0;
    v = '{4'b0001, 32'h0000_0FFC, 3'd2, 0, 0, 32'h0FFC_0FFC, 2'b00, 0};
    run_txn(v);
`endif

    // Random traffic against the round-robin reference model.
    for (int i = 0; i < 40; i++) begin
      v.mask    = 4'($urandom_range(1, 15));
      v.addr    = 32'($urandom_range(0, 32'hE00)) & 32'hFFFF_FFFC;
      v.prot    = 3'($urandom_range(0, 7));
      v.ar_wait = $urandom_range(0, 3);
      v.r_wait  = $urandom_range(0, 3);
      v.rdata   = $urandom;
      v.rresp   = 2'($urandom_range(0, 3));
      g         = model_grant(v.mask);
      v.g       = g;
      run_txn(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
